uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_overflow,
  output logic       uart_out
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t             state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               uart_out_q, uart_out_d;
  logic               tx_overflow_q, tx_overflow_d;
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic baud_last;
  logic pop;
  logic push;

  assign baud_last = (baud_q == BAUD_LAST);
  assign pop       = (state_q == IDLE) && (count_q != '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = tx_start && ((count_q != FULL_CNT) || pop);

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_idx_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      uart_out_q    <= 1'b1;
      tx_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_idx_q     <= bit_idx_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      uart_out_q    <= uart_out_d;
      tx_overflow_q <= tx_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= tx_data;
    end
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (pop) state_d = START;
      START: if (baud_last) state_d = DATA;
      DATA: begin
        if (baud_last && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) state_d = STOP;
`endif
      STOP:  if (baud_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: baud/bit counters, shift register and FIFO bookkeeping
  always_comb begin
    baud_d        = '0;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    tx_overflow_d = tx_start && !push;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    if (state_q != IDLE) begin
      baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
    end

    if (state_q == START) begin
      bit_idx_d = '0;
    end else if ((state_q == DATA) && baud_last) begin
      bit_idx_d = bit_idx_q + 3'd1;
      shift_d   = {1'b0, shift_q[7:1]};
    end

    if (pop) begin
      shift_d  = fifo_mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_mem_q[rd_ptr_q];
`endif
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Output logic; the line level is registered from the upcoming state
  always_comb begin
    uart_out_d = 1'b1;
    case (state_d)
      IDLE:   uart_out_d = 1'b1;
      START:  uart_out_d = 1'b0;
      DATA:   uart_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: uart_out_d = parity_q;
`endif
      STOP:   uart_out_d = 1'b1;
      default: uart_out_d = 1'b1;
    endcase
    tx_done = (state_q == STOP) && baud_last;
    tx_busy = (state_q != IDLE) || (count_q != '0);
  end

  assign tx_full     = (count_q == FULL_CNT);
  assign tx_overflow = tx_overflow_q;
  assign uart_out    = uart_out_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Frame vectors are hand-written for both 8N1 and the UART_TX_PARITY_EN build.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_full;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_overflow;
  logic       uart_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // bit i is the i-th transmitted bit, start bit first
  } vec_t;

  vec_t vecs [10];
  int   burst_idx [8];
  logic uo_tr   [0:1023];
  logic full_tr [0:1023];

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_full     (tx_full),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_overflow (tx_overflow),
    .uart_out    (uart_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Single byte from idle: latency, every bit centre, tx_done timing, idle afterwards.
  task automatic send_frame(input int vi);
    int done_cnt, done_off, fall_off;
    done_cnt = 0;
    done_off = -1;
    fall_off = -1;
    tx_data  = vecs[vi].data;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int t = 1; t <= 4 * FL + 5; t++) begin
      if (fall_off < 0 && uart_out == 1'b0) fall_off = t;
      if (tx_done) begin
        done_cnt++;
        done_off = t;
      end
      if (t >= 4 && ((t - 4) % 4) == 0 && ((t - 4) / 4) < FL)
        check($sformatf("v%0d bit%0d", vi, (t - 4) / 4), 32'(uart_out),
              32'(vecs[vi].frame[(t - 4) / 4]));
      step();
    end
    check($sformatf("v%0d fall latency", vi), fall_off, 2);
    check($sformatf("v%0d done count", vi), done_cnt, 1);
    check($sformatf("v%0d done offset", vi), done_off, 4 * FL + 1);
    check($sformatf("v%0d busy after", vi), 32'(tx_busy), 0);
    check($sformatf("v%0d line after", vi), 32'(uart_out), 1);
  endtask

  // Consecutive strobes on burst_idx[0..ns-1]; expects nexp back-to-back frames.
  task automatic run_burst(input string tag, input int ns, input int nexp,
                           input int exp_ovf, input int full_t);
    int h, done_cnt, ovf_cnt, ovf_off, st;
    h = 2 + nexp * (4 * FL + 1) + 8;
    done_cnt = 0;
    ovf_cnt  = 0;
    ovf_off  = -1;
    for (int t = 0; t < h; t++) begin
      uo_tr[t]   = uart_out;
      full_tr[t] = tx_full;
      if (tx_done) done_cnt++;
      if (tx_overflow) begin
        ovf_cnt++;
        ovf_off = t;
      end
      tx_start = (t < ns);
      tx_data  = (t < ns) ? vecs[burst_idx[t]].data : 8'h00;
      step();
    end
    tx_start = 1'b0;
    for (int k = 0; k < nexp; k++) begin
      st = 2 + k * (4 * FL + 1);
      check($sformatf("%s f%0d pre-start high", tag, k), 32'(uo_tr[st - 1]), 1);
      check($sformatf("%s f%0d start edge", tag, k), 32'(uo_tr[st]), 0);
      for (int i = 0; i < FL; i++)
        check($sformatf("%s f%0d bit%0d", tag, k, i), 32'(uo_tr[st + 2 + 4 * i]),
              32'(vecs[burst_idx[k]].frame[i]));
    end
    check({tag, " done count"}, done_cnt, nexp);
    check({tag, " overflow count"}, ovf_cnt, exp_ovf);
    if (exp_ovf > 0) check({tag, " overflow offset"}, ovf_off, ns);
    if (full_t > 0) begin
      check({tag, " full before"}, 32'(full_tr[full_t - 1]), 0);
      check({tag, " full"}, 32'(full_tr[full_t]), 1);
    end
    check({tag, " busy after"}, 32'(tx_busy), 0);
    check({tag, " line after"}, 32'(uart_out), 1);
  endtask

  initial begin
    int done_cnt, bad_line;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b10101001010};
    vecs[1] = '{8'h00, 11'b10000000000};
    vecs[2] = '{8'hFF, 11'b10111111110};
    vecs[3] = '{8'h01, 11'b11000000010};
    vecs[4] = '{8'h02, 11'b11000000100};
    vecs[5] = '{8'h03, 11'b10000000110};
    vecs[6] = '{8'h04, 11'b11000001000};
    vecs[7] = '{8'h80, 11'b11100000000};
    vecs[8] = '{8'h3C, 11'b10001111000};
    vecs[9] = '{8'h07, 11'b11000001110};
`else
    vecs[0] = '{8'hA5, 11'b01101001010};
    vecs[1] = '{8'h00, 11'b01000000000};
    vecs[2] = '{8'hFF, 11'b01111111110};
    vecs[3] = '{8'h01, 11'b01000000010};
    vecs[4] = '{8'h02, 11'b01000000100};
    vecs[5] = '{8'h03, 11'b01000000110};
    vecs[6] = '{8'h04, 11'b01000001000};
    vecs[7] = '{8'h80, 11'b01100000000};
    vecs[8] = '{8'h3C, 11'b01001111000};
    vecs[9] = '{8'h07, 11'b01000001110};
`endif

    nreset   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    step();
    step();
    check("reset line", 32'(uart_out), 1);
    check("reset busy", 32'(tx_busy), 0);
    check("reset full", 32'(tx_full), 0);
    check("reset done", 32'(tx_done), 0);
    check("reset overflow", 32'(tx_overflow), 0);
    nreset = 1'b1;

    // Quiet line after reset release
    done_cnt = 0;
    bad_line = 0;
    for (int t = 0; t < 100; t++) begin
      if (tx_done) done_cnt++;
      if (uart_out !== 1'b1 || tx_busy !== 1'b0) bad_line++;
      step();
    end
    check("idle done pulses", done_cnt, 0);
    check("idle line/busy faults", bad_line, 0);

    // Every table byte as an isolated frame
    for (int v = 0; v < 10; v++) begin
      send_frame(v);
      step();
    end

    // Four queued bytes back to back
    burst_idx[0] = 3; burst_idx[1] = 4; burst_idx[2] = 5; burst_idx[3] = 6;
    run_burst("burst4", 4, 4, 0, -1);
    step();

    // Six strobes into a 4-deep FIFO: one popped, four queued, one dropped
    burst_idx[0] = 3; burst_idx[1] = 4; burst_idx[2] = 5; burst_idx[3] = 6;
    burst_idx[4] = 0; burst_idx[5] = 2;
    run_burst("overflow6", 6, 5, 1, 5);
    step();

    // Reset in the middle of the data bits of 0xFF
    done_cnt = 0;
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    for (int t = 1; t < 14; t++) begin
      if (tx_done) done_cnt++;
      step();
    end
    check("pre-abort data bit", 32'(uart_out), 1);
    check("pre-abort busy", 32'(tx_busy), 1);
    #2;
    nreset = 1'b0;
    #1;
    check("abort line", 32'(uart_out), 1);
    check("abort busy", 32'(tx_busy), 0);
    step();
    step();
    nreset = 1'b1;
    bad_line = 0;
    for (int t = 0; t < 60; t++) begin
      if (tx_done) done_cnt++;
      if (uart_out !== 1'b1 || tx_busy !== 1'b0) bad_line++;
      step();
    end
    check("abort done pulses", done_cnt, 0);
    check("abort line/busy faults", bad_line, 0);
    send_frame(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
